// File: rtl/fpu_addsub_arbiter.sv
// ============================================================================
// fpu_addsub_arbiter
// Round-robin sharing of one pipelined fsub unit between two requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_addsub_arbiter #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_op,
  input  logic [31:0]      a_x1,
  input  logic [31:0]      a_x2,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_op,
  input  logic [31:0]      b_x1,
  input  logic [31:0]      b_x2,
  input  logic [TAG_W-1:0] b_tag,
  output logic [31:0]      fu_x1,
  output logic [31:0]      fu_x2,
  input  logic [31:0]      fu_y,
  output logic             ra_valid,
  input  logic             ra_ready,
  output logic [31:0]      ra_y,
  output logic [TAG_W-1:0] ra_tag,
  output logic             rb_valid,
  input  logic             rb_ready,
  output logic [31:0]      rb_y,
  output logic [TAG_W-1:0] rb_tag,
  output logic             busy
);

  localparam int               c_AW    = $clog2(DEPTH);
  localparam int               c_CW    = c_AW + 1;
  localparam int               c_EW    = TAG_W + 32;
  localparam logic [c_CW:0]    c_DEPTH = (c_CW + 1)'(DEPTH);

  logic                r_prio;
  logic [LAT-1:0]      r_trk_v;
  logic [LAT-1:0]      r_trk_port;
  logic [TAG_W-1:0]    r_trk_tag [LAT];
  logic [c_CW-1:0]     r_cnt     [2];
  logic [c_CW-1:0]     r_infl    [2];
  logic [c_AW-1:0]     r_wp      [2];
  logic [c_AW-1:0]     r_rp      [2];
  logic [c_EW-1:0]     r_mem     [2][DEPTH];

  logic [1:0]          w_cred;
  logic [1:0]          w_ne;
  logic [1:0]          w_elig;
  logic [1:0]          w_gnt;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic                w_ret_v;
  logic                w_ret_port;
  logic [TAG_W-1:0]    w_ret_tag;
  logic [c_EW-1:0]     w_head_a;
  logic [c_EW-1:0]     w_head_b;

  // Credit counts both queued and in-flight results so a FIFO can never overflow.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_cred[p] = ({1'b0, r_cnt[p]} + {1'b0, r_infl[p]}) < c_DEPTH;
      w_ne[p]   = (r_cnt[p] != '0);
    end
  end

  assign w_elig   = {b_valid, a_valid} & w_cred & {2{rstn}};
  assign w_gnt[0] = w_elig[0] & (~w_elig[1] | ~r_prio);
  assign w_gnt[1] = w_elig[1] & (~w_elig[0] |  r_prio);
  assign a_ready  = w_gnt[0];
  assign b_ready  = w_gnt[1];

  // Add is issued as subtract of the negated second operand.
  always_comb begin
    fu_x1 = '0;
    fu_x2 = '0;
    if (w_gnt[0]) begin
      fu_x1 = a_x1;
      fu_x2 = a_op ? a_x2 : {~a_x2[31], a_x2[30:0]};
    end else if (w_gnt[1]) begin
      fu_x1 = b_x1;
      fu_x2 = b_op ? b_x2 : {~b_x2[31], b_x2[30:0]};
    end
  end

  assign w_ret_v    = r_trk_v[LAT-1];
  assign w_ret_port = r_trk_port[LAT-1];
  assign w_ret_tag  = r_trk_tag[LAT-1];
  assign w_push[0]  = w_ret_v & ~w_ret_port;
  assign w_push[1]  = w_ret_v &  w_ret_port;
  assign w_pop      = w_ne & {rb_ready, ra_ready};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prio     <= 1'b0;
      r_trk_v    <= '0;
      r_trk_port <= '0;
      for (int i = 0; i < LAT; i++) r_trk_tag[i] <= '0;
      for (int p = 0; p < 2; p++) begin
        r_cnt[p]  <= '0;
        r_infl[p] <= '0;
        r_wp[p]   <= '0;
        r_rp[p]   <= '0;
      end
    end else begin
      if (|w_gnt) r_prio <= w_gnt[0];
      r_trk_v[0]    <= |w_gnt;
      r_trk_port[0] <= w_gnt[1];
      r_trk_tag[0]  <= w_gnt[1] ? b_tag : a_tag;
      for (int i = 1; i < LAT; i++) begin
        r_trk_v[i]    <= r_trk_v[i-1];
        r_trk_port[i] <= r_trk_port[i-1];
        r_trk_tag[i]  <= r_trk_tag[i-1];
      end
      for (int p = 0; p < 2; p++) begin
        if (w_push[p] && !w_pop[p])      r_cnt[p] <= r_cnt[p] + 1'b1;
        else if (!w_push[p] && w_pop[p]) r_cnt[p] <= r_cnt[p] - 1'b1;
        if (w_gnt[p] && !w_push[p])      r_infl[p] <= r_infl[p] + 1'b1;
        else if (!w_gnt[p] && w_push[p]) r_infl[p] <= r_infl[p] - 1'b1;
        if (w_push[p]) r_wp[p] <= r_wp[p] + 1'b1;
        if (w_pop[p])  r_rp[p] <= r_rp[p] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (w_push[p]) r_mem[p][r_wp[p]] <= {w_ret_tag, fu_y};
    end
  end

  // Head is masked so an empty FIFO presents zeros rather than stale storage.
  assign w_head_a = w_ne[0] ? r_mem[0][r_rp[0]] : '0;
  assign w_head_b = w_ne[1] ? r_mem[1][r_rp[1]] : '0;

  assign ra_valid = w_ne[0];
  assign {ra_tag, ra_y} = w_head_a;
  assign rb_valid = w_ne[1];
  assign {rb_tag, rb_y} = w_head_b;

  assign busy = (|r_trk_v) | (|w_ne);

endmodule

`default_nettype wire

// File: tb/tb_fpu_addsub_arbiter.sv
// ============================================================================
// tb_fpu_addsub_arbiter
// Directed bench with a behavioural single-cycle fsub unit model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpu_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_valid, a_ready, a_op, b_valid, b_ready, b_op;
  logic [31:0] a_x1, a_x2, b_x1, b_x2, fu_x1, fu_x2, fu_y, ra_y, rb_y;
  logic [3:0]  a_tag, b_tag, ra_tag, rb_tag;
  logic        ra_valid, ra_ready, rb_valid, rb_ready, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.LAT(1), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x1(a_x1), .a_x2(a_x2), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x1(b_x1), .b_x2(b_x2), .b_tag(b_tag),
    .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_y(fu_y),
    .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_y(ra_y), .ra_tag(ra_tag),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_y(rb_y), .rb_tag(rb_tag),
    .busy(busy)
  );

  // Single to double conversion for normal numbers and zero only.
  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'h0) return {s[31], 63'h0};
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'h0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fsub_model(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = $bitstoreal(s2d(x));
    ry = $bitstoreal(s2d(y));
    return d2s($realtobits(rx - ry));
  endfunction

  always @(posedge clk) fu_y <= fsub_model(fu_x1, fu_x2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  typedef struct packed {
    logic        port;
    logic        op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [3:0]  tag;
    logic [31:0] fx2;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [6];
  int   na, nb, ga;
  logic gA, gB, exp_a;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h3F800000, 32'h40000000, 4'd3,  32'hC0000000, 32'h40400000};
    vecs[1] = '{1'b1, 1'b1, 32'h40400000, 32'h3F800000, 4'd5,  32'h3F800000, 32'h40000000};
    vecs[2] = '{1'b0, 1'b1, 32'h3F800000, 32'h40000000, 4'd7,  32'h40000000, 32'hBF800000};
    vecs[3] = '{1'b1, 1'b0, 32'h40A00000, 32'hC0400000, 4'd9,  32'h40400000, 32'h40000000};
    vecs[4] = '{1'b0, 1'b0, 32'h3F000000, 32'h3F000000, 4'd15, 32'hBF000000, 32'h3F800000};
    vecs[5] = '{1'b1, 1'b0, 32'h3F800000, 32'hBF800000, 4'd0,  32'h3F800000, 32'h00000000};

    a_valid = 1'b1; b_valid = 1'b1; a_op = 1'b0; b_op = 1'b0;
    a_x1 = 32'h3F800000; a_x2 = 32'h3F800000; b_x1 = 32'h3F800000; b_x2 = 32'h3F800000;
    a_tag = 4'd1; b_tag = 4'd2; ra_ready = 1'b1; rb_ready = 1'b1;

    // Reset state with valids asserted.
    #2;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_ra_valid", ra_valid, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_ra_y", {ra_tag, ra_y}, 0);
    check("rst_rb_y", {rb_tag, rb_y}, 0);
    check("rst_busy", busy, 0);
    check("rst_fu", {fu_x1, fu_x2}, 0);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].port) begin
        a_valid = 1'b1; a_op = vecs[v].op; a_x1 = vecs[v].x1; a_x2 = vecs[v].x2; a_tag = vecs[v].tag;
      end else begin
        b_valid = 1'b1; b_op = vecs[v].op; b_x1 = vecs[v].x1; b_x2 = vecs[v].x2; b_tag = vecs[v].tag;
      end
      @(negedge clk);
      check("vec_ready", vecs[v].port ? b_ready : a_ready, 1);
      check("vec_fu_x1", fu_x1, vecs[v].x1);
      check("vec_fu_x2", fu_x2, vecs[v].fx2);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      check("vec_early", vecs[v].port ? rb_valid : ra_valid, 0);
      check("vec_busy_flight", busy, 1);
      tick();
      @(negedge clk);
      check("vec_valid", vecs[v].port ? rb_valid : ra_valid, 1);
      check("vec_y", vecs[v].port ? rb_y : ra_y, vecs[v].y);
      check("vec_tag", vecs[v].port ? rb_tag : ra_tag, vecs[v].tag);
      check("vec_other_silent", vecs[v].port ? ra_valid : rb_valid, 0);
      tick();
      @(negedge clk);
      check("vec_busy_done", busy, 0);
      check("vec_drained", ra_valid | rb_valid, 0);
      tick();
    end

    // Contention: alternate A,B starting with A.
    do_reset();
    ra_ready = 1'b1; rb_ready = 1'b1;
    a_op = 1'b1; b_op = 1'b1; a_tag = 4'd0; b_tag = 4'd0;
    a_valid = 1'b1; b_valid = 1'b1; na = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin a_valid = 1'b0; b_valid = 1'b0; end
      @(negedge clk);
      if (i < 8) begin
        check("rr_a_ready", a_ready, (i % 2 == 0));
        check("rr_b_ready", b_ready, (i % 2 == 1));
      end
      if (ra_valid) begin check("rr_a_order", ra_tag, na); na++; end
      if (rb_valid) begin check("rr_b_order", rb_tag, nb); nb++; end
      gA = a_ready; gB = b_ready;
      tick();
      if (gA) a_tag++;
      if (gB) b_tag++;
    end
    check("rr_a_count", na, 4);
    check("rr_b_count", nb, 4);

    // Back-pressure on response A.
    do_reset();
    ra_ready = 1'b0; rb_ready = 1'b1;
    a_tag = 4'd0; b_tag = 4'd0; a_valid = 1'b1; b_valid = 1'b1; nb = 0; ga = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_a = (i < 8) && (i % 2 == 0);
      check("bp_a_ready", a_ready, exp_a);
      check("bp_b_ready", b_ready, !exp_a);
      if (rb_valid) begin check("bp_b_order", rb_tag, nb); nb++; end
      gA = a_ready; gB = b_ready;
      tick();
      if (gA) begin a_tag++; ga++; end
      if (gB) b_tag++;
    end
    check("bp_a_grants", ga, 4);
    ra_ready = 1'b1; b_valid = 1'b0; na = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check("bp_credit_hold", a_ready, 0);
      if (i == 1) check("bp_credit_back", a_ready, 1);
      if (ra_valid) begin check("bp_a_order", ra_tag, na); na++; end
      gA = a_ready && a_valid;
      tick();
      if (gA) begin
        if (a_tag == 4'd7) a_valid = 1'b0;
        a_tag++;
      end
    end
    check("bp_a_total", na, 8);

    // Simultaneous push and pop on FIFO A.
    do_reset();
    ra_ready = 1'b0; a_op = 1'b1; a_x1 = 32'h40400000; a_x2 = 32'h3F800000;
    a_valid = 1'b1; a_tag = 4'd1;
    tick();
    a_tag = 4'd2;
    tick();
    a_valid = 1'b0; ra_ready = 1'b1;
    @(negedge clk);
    check("pp_head_valid", ra_valid, 1);
    check("pp_head_tag", ra_tag, 1);
    tick();
    @(negedge clk);
    check("pp_second_valid", ra_valid, 1);
    check("pp_second_tag", ra_tag, 2);
    check("pp_second_y", ra_y, 32'h40000000);
    tick();
    @(negedge clk);
    check("pp_empty", ra_valid, 0);
    check("pp_busy", busy, 0);
    tick();

    // Reset while a result is in flight.
    do_reset();
    ra_ready = 1'b1; a_valid = 1'b1; a_tag = 4'd6;
    @(negedge clk);
    check("mr_grant", a_ready, 1);
    tick();
    a_valid = 1'b0; rstn = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_ra_valid", ra_valid, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mr_no_stale", {ra_valid, rb_valid, busy}, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
